// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue: issues 16-bit code fetches, buffers the returned
// bytes in a circular store and presents the head three bytes plus a count to pre-decode.
module prefetch_queue #(
  parameter int DEPTH = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        flush,
  input  logic [15:0] flush_addr,
  input  logic [2:0]  consume,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic [3:0]  q_len,
  output logic [7:0]  q0,
  output logic [7:0]  q1,
  output logic [7:0]  q2,
  output logic [15:0] q_ip
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  logic [7:0]  mem   [0:7];
  logic [7:0]  mem_n [0:7];
  logic [2:0]  rd, wr, rd_n, wr_n;
  logic [3:0]  count, count_n, cons, count_c, space;
  logic [15:0] ip_n, fa_n;
  state_t      state, state_n;
  logic        discard, discard_n;
  logic [7:0]  q0_n, q1_n, q2_n;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [2:0] wrap(input logic [2:0] p, input logic [2:0] n);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, n};
    if (s >= DEPTH_L) s = s - DEPTH_L;
    return s[2:0];
  endfunction

  assign fetch_req = (state == WAIT);
  assign q_len     = count;

  always_comb begin
    cons      = ({1'b0, consume} > count) ? count : {1'b0, consume};
    count_c   = count - cons;
    space     = DEPTH_L - count_c;
    mem_n     = mem;
    rd_n      = rd;
    wr_n      = wr;
    count_n   = count;
    ip_n      = q_ip;
    fa_n      = fetch_addr;
    state_n   = state;
    discard_n = discard;

    if (flush) begin
      rd_n      = 3'd0;
      wr_n      = 3'd0;
      count_n   = 4'd0;
      ip_n      = flush_addr;
      fa_n      = flush_addr;
      state_n   = IDLE;
      // An outstanding fetch that has not been acked yet must have its ack swallowed later.
      discard_n = ((state == WAIT) || discard) && !fetch_ack;
    end else begin
      rd_n    = wrap(rd, cons[2:0]);
      count_n = count_c;
      ip_n    = q_ip + {12'h000, cons};
      case (state)
        IDLE: begin
          if (discard) begin
            if (fetch_ack) discard_n = 1'b0;
          end else if ((space >= 4'd2) || ((space >= 4'd1) && fetch_addr[0])) begin
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (fetch_ack) begin
            state_n = IDLE;
            if (fetch_addr[0]) begin
              mem_n[wr] = fetch_data[15:8];
              wr_n      = wrap(wr, 3'd1);
              count_n   = count_c + 4'd1;
              fa_n      = fetch_addr + 16'd1;
            end else begin
              mem_n[wr]             = fetch_data[7:0];
              mem_n[wrap(wr, 3'd1)] = fetch_data[15:8];
              wr_n                  = wrap(wr, 3'd2);
              count_n               = count_c + 4'd2;
              fa_n                  = fetch_addr + 16'd2;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    q0_n = (count_n >= 4'd1) ? mem_n[rd_n]              : 8'h00;
    q1_n = (count_n >= 4'd2) ? mem_n[wrap(rd_n, 3'd1)]  : 8'h00;
    q2_n = (count_n >= 4'd3) ? mem_n[wrap(rd_n, 3'd2)]  : 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd         <= 3'd0;
      wr         <= 3'd0;
      count      <= 4'd0;
      q_ip       <= 16'h0000;
      fetch_addr <= 16'h0000;
      state      <= IDLE;
      discard    <= 1'b0;
      q0         <= 8'h00;
      q1         <= 8'h00;
      q2         <= 8'h00;
    end else if (ce) begin
      rd         <= rd_n;
      wr         <= wr_n;
      count      <= count_n;
      q_ip       <= ip_n;
      fetch_addr <= fa_n;
      state      <= state_n;
      discard    <= discard_n;
      q0         <= q0_n;
      q1         <= q1_n;
      q2         <= q2_n;
    end
  end

  // Byte storage carries no reset; unwritten slots are masked by count on the head outputs.
  always_ff @(posedge clk) begin
    if (ce) mem <= mem_n;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: returned bytes are queued on ack and retired on consume.
module tb_prefetch_queue;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_addr = 16'h0000;
  logic [2:0]  consume = 3'd0;
  logic        fetch_ack = 1'b0;
  logic [15:0] fetch_data = 16'h0000;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [3:0]  q_len;
  logic [7:0]  q0, q1, q2;
  logic [15:0] q_ip;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_ip = 16'h0000;
  logic [15:0] exp_fa = 16'h0000;
  bit          swallow = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  prefetch_queue #(.DEPTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush), .flush_addr(flush_addr),
    .consume(consume), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .q_len(q_len),
    .q0(q0), .q1(q1), .q2(q2), .q_ip(q_ip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("q_len", {28'h0, q_len}, 32'(n));
    check("q0", {24'h0, q0}, {24'h0, (n > 0) ? exp_q[0] : 8'h00});
    check("q1", {24'h0, q1}, {24'h0, (n > 1) ? exp_q[1] : 8'h00});
    check("q2", {24'h0, q2}, {24'h0, (n > 2) ? exp_q[2] : 8'h00});
    check("q_ip", {16'h0, q_ip}, {16'h0, exp_ip});
    check("fetch_addr", {16'h0, fetch_addr}, {16'h0, exp_fa});
  endtask

  // One clock: drive inputs, take the edge, update the scoreboard, compare.
  task automatic step(input bit f, input logic [15:0] fa, input int cons, input bit ack,
                      input logic [15:0] data, input bit en);
    bit req_before;
    int n;
    req_before = fetch_req;
    ce = en; flush = f; flush_addr = fa; consume = 3'(cons); fetch_ack = ack; fetch_data = data;
    @(posedge clk); #1;
    ce = 1'b1; flush = 1'b0; consume = 3'd0; fetch_ack = 1'b0;
    if (en) begin
      if (f) begin
        exp_q.delete();
        exp_ip  = fa;
        exp_fa  = fa;
        swallow = (swallow || req_before) && !ack;
      end else begin
        n = (cons > exp_q.size()) ? exp_q.size() : cons;
        repeat (n) void'(exp_q.pop_front());
        exp_ip = exp_ip + 16'(n);
        if (ack) begin
          if (swallow) swallow = 1'b0;
          else if (exp_fa[0]) begin
            exp_q.push_back(data[15:8]);
            exp_fa = exp_fa + 16'd1;
          end else begin
            exp_q.push_back(data[7:0]);
            exp_q.push_back(data[15:8]);
            exp_fa = exp_fa + 16'd2;
          end
        end
      end
    end
    check_outputs();
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !fetch_req; i++) step(0, 16'h0, 0, 0, 16'h0, 1);
    check("req_timeout", {31'h0, fetch_req}, 32'd1);
  endtask

  initial begin
    int words;
    bit a;
    #3;
    check_outputs();
    check("reset_req", {31'h0, fetch_req}, 32'd0);
    #9 reset_n = 1'b1;
    ce = 1'b1;

    // Sequential fill from 0100 until full.
    step(1, 16'h0100, 0, 0, 16'h0, 1);
    wait_req();
    check("fa_0100", {16'h0, fetch_addr}, 32'h0100);
    step(0, 16'h0, 0, 1, 16'h2211, 1);
    wait_req();
    check("fa_0102", {16'h0, fetch_addr}, 32'h0102);
    step(0, 16'h0, 0, 1, 16'h4433, 1);
    wait_req();
    check("fa_0104", {16'h0, fetch_addr}, 32'h0104);
    step(0, 16'h0, 0, 1, 16'h6655, 1);
    check("full_len", {28'h0, q_len}, 32'd6);
    check("head", {8'h0, q0, q1, q2}, 32'h00112233);
    step(0, 16'h0, 0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 0, 16'h0, 1);
    check("no_req_full", {31'h0, fetch_req}, 32'd0);

    // Full queue, consume 3 with no request outstanding.
    step(0, 16'h0, 3, 0, 16'h0, 1);
    check("ip_adv3", {16'h0, q_ip}, 32'h0103);
    check("req_after_consume", {31'h0, fetch_req}, 32'd1);
    step(0, 16'h0, 0, 1, 16'h8877, 1);
    check("len_after_refill", {28'h0, q_len}, 32'd5);

    // Odd flush target: only the high byte is kept.
    step(1, 16'h0201, 0, 0, 16'h0, 1);
    wait_req();
    check("fa_odd", {16'h0, fetch_addr}, 32'h0201);
    step(0, 16'h0, 0, 1, 16'hAABB, 1);
    check("odd_len", {28'h0, q_len}, 32'd1);
    check("odd_q0", {24'h0, q0}, 32'hAA);
    check("fa_realign", {16'h0, fetch_addr}, 32'h0202);

    // Flush while a fetch is in flight; its late ack must be swallowed.
    wait_req();
    step(1, 16'h0300, 0, 0, 16'h0, 1);
    check("req_drop", {31'h0, fetch_req}, 32'd0);
    step(0, 16'h0, 0, 0, 16'h0, 1);
    check("req_hold_discard", {31'h0, fetch_req}, 32'd0);
    step(0, 16'h0, 0, 1, 16'hDEAD, 1);
    check("discard_len", {28'h0, q_len}, 32'd0);
    check("req_after_swallow", {31'h0, fetch_req}, 32'd0);
    wait_req();
    check("fa_after_flush", {16'h0, fetch_addr}, 32'h0300);

    // Stream 20 words while consuming 2 bytes per cycle.
    words = 0;
    for (int c = 0; c < 200 && words < 20; c++) begin
      a = fetch_req;
      step(0, 16'h0, 2, a, {8'(2 * words + 1), 8'(2 * words)}, 1);
      if (a) words++;
    end
    check("stream_words", 32'(words), 32'd20);

    // Clock enable low mid-WAIT: nothing moves.
    wait_req();
    for (int i = 0; i < 5; i++) step(0, 16'h0, 2, 1, 16'h5A5A, 0);
    check("ce_req_hold", {31'h0, fetch_req}, 32'd1);

    // Asynchronous reset mid-WAIT.
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ip  = 16'h0000;
    exp_fa  = 16'h0000;
    swallow = 1'b0;
    check_outputs();
    check("async_reset_req", {31'h0, fetch_req}, 32'd0);
    reset_n = 1'b1;
    wait_req();
    check("fa_after_reset", {16'h0, fetch_addr}, 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
Byte-wide instruction prefetch queue that sits directly upstream of the pre-decode stage. It issues 16-bit code fetches to the bus unit and stores the returned bytes. It presents the head three bytes plus a byte count (q_len) to pre-decode, and retires bytes when the execute side consumes them. It also handles branch flushes, including discarding a fetch that is still in flight when the flush arrives.

Parameters:
DEPTH, 6, queue capacity in bytes (legal 4..8; wrap logic must not assume a power of two)

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
ce  input  1  clock enable; all state advances only on clk edges with ce=1
flush  input  1  discard queue contents and restart fetching at flush_addr
flush_addr  input  16  new code offset (IP) after a flush
consume  input  3  number of bytes retired from the head this cycle (0..3)
fetch_req  output  1  request a code word fetch
fetch_addr  output  16  code offset of the requested fetch (the bus unit applies CS)
fetch_ack  input  1  fetch accepted and completed; fetch_data valid
fetch_data  input  16  returned word, little-endian (low byte at the even address)
q_len  output  4  bytes currently valid in the queue
q0  output  8  head byte
q1  output  8  head+1 byte
q2  output  8  head+2 byte
q_ip  output  16  code offset of q0

Behaviour:
- Reset (async, reset_n=0):
  - q_len=0, q0/q1/q2=8'h00, q_ip=0.
  - fetch_req=0, fetch_addr=0.
  - Internal read/write pointers=0; pending/discard flags=0.
- Storage: circular byte buffer of DEPTH entries with a read pointer, a write pointer and a count. Pointers wrap from DEPTH-1 to 0.
- Head outputs are registered and reflect the state after the update:
  - q0/q1/q2 = buf[rd], buf[rd+1], buf[rd+2] (mod DEPTH).
  - Bytes at or beyond q_len are don't-care but must be deterministic; drive 0.
- Fetch state machine: IDLE, WAIT.
  - IDLE -> WAIT when free space (DEPTH - count_after_consume) >= 2, or >= 1 if fetch_addr is odd. On this transition fetch_req=1 and fetch_addr holds.
  - WAIT: hold fetch_req=1 and fetch_addr stable until fetch_ack; then return to IDLE.
  - Even fetch_addr: both bytes are written (low byte first) and fetch_addr += 2.
  - Odd fetch_addr: only the high byte is written and fetch_addr += 1, realigning to even.
  - fetch_addr wraps modulo 2^16.
- Consume:
  - rd += consume, count -= consume, q_ip += consume (mod 2^16).
  - If consume > count, clamp to count.
- Same-cycle consume and fetch_ack: the consume is applied first, then the write. q_len = old - consume + written. The result never exceeds DEPTH, guaranteed by the space check at request time.
- Flush:
  - count=0, rd=wr=0, q_ip=flush_addr, fetch_addr=flush_addr.
  - consume and any fetch_ack data in the same cycle are ignored.
  - If in WAIT without ack, set a discard flag, drop fetch_req the next cycle, and return to IDLE. The next ack is swallowed: no write, no address update.
  - A new request may be issued only after the discarded ack has been seen.
  - Flush has priority over every other event.
- ce=0: no state change; outputs hold; fetch_ack is ignored (the bus unit only acks on ce cycles).
- Latency:
  - fetch_ack at edge N -> bytes visible in q_len/q* after edge N.
  - fetch_req re-asserts no earlier than the edge after an ack.
- q_len width is 4 bits; DEPTH<=8 guarantees no overflow.

Test Plan:
- Reset, flush_addr=16'h0100, acks returning 16'h2211, then 16'h4433, then 16'h6655 -> fetch_addr sequence 0100, 0102, 0104; q_len 2, 4, 6; q0..q2=11,22,33; no request while full.
- Flush to 16'h0201 (odd), ack 16'hAABB -> only AA stored, q_len=1, next fetch_addr=0202.
- Full queue (6), consume=3 with simultaneous ack -> q_len=5 only if a request was outstanding. Otherwise verify the request reappears with free space 3 and q_ip advances by 3.
- Flush asserted during WAIT, ack arrives two cycles later with 16'hDEAD -> q_len stays 0, DE/AD never appear; first new fetch_addr equals flush_addr.
- Wrap-around: run 20 words through while consuming 2 per cycle -> byte order at q0 matches the fetched stream exactly; pointers wrap at DEPTH.
- ce held low for 5 cycles mid-WAIT with consume=2 -> no change to q_len, q_ip or fetch_addr; reset_n pulsed low mid-WAIT -> all outputs return to reset values asynchronously.
